// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - N-stage pipeline register chain with stall/flush control and event counters
// Stage 0 is youngest, stage N_STAGES-1 drives out_*.

module pipe_evt_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             evt,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (evt && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

module pipe_stage_chain #(
  parameter int                N_STAGES   = 4,
  parameter int                DAT_W      = 32,
  parameter logic [DAT_W-1:0]  BUBBLE_DAT = 32'h0000_0013,
  parameter int                CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [DAT_W-1:0]          in_dat,
  input  logic [N_STAGES-1:0]       stall,
  input  logic [N_STAGES-1:0]       flush,
  output logic [N_STAGES-1:0]       stg_vld,
  output logic [N_STAGES*DAT_W-1:0] stg_dat,
  output logic                      out_vld,
  output logic [DAT_W-1:0]          out_dat,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  logic [N_STAGES-1:0] hold;
  logic [N_STAGES-1:0] kill;
  logic [N_STAGES-1:0] prev_hold;
  logic [N_STAGES-1:0] src_vld;
  logic [DAT_W-1:0]    src_dat [N_STAGES];
  logic [N_STAGES-1:0] vld_q;
  logic [DAT_W-1:0]    dat_q   [N_STAGES];

  // A stall or flush at stage k reaches every younger stage j <= k.
  genvar g;
  generate
    for (g = 0; g < N_STAGES; g++) begin : g_ctl
      assign hold[g] = |(stall >> g);
      assign kill[g] = |(flush >> g);
      assign stg_dat[g*DAT_W +: DAT_W] = dat_q[g];
      if (g == 0) begin : g_head
        assign prev_hold[g] = 1'b0;
        assign src_vld[g]   = in_vld;
        assign src_dat[g]   = in_vld ? in_dat : BUBBLE_DAT;
      end else begin : g_body
        assign prev_hold[g] = hold[g-1];
        assign src_vld[g]   = vld_q[g-1];
        assign src_dat[g]   = dat_q[g-1];
      end
    end
  endgenerate

  // Priority per stage: kill, hold, bubble behind a stall, advance.
  always_ff @(posedge clk) begin
    for (int j = 0; j < N_STAGES; j++) begin
      if (rst || kill[j]) begin
        vld_q[j] <= 1'b0;
        dat_q[j] <= BUBBLE_DAT;
      end else if (hold[j]) begin
        vld_q[j] <= vld_q[j];
        dat_q[j] <= dat_q[j];
      end else if (prev_hold[j]) begin
        vld_q[j] <= 1'b0;
        dat_q[j] <= BUBBLE_DAT;
      end else begin
        vld_q[j] <= src_vld[j];
        dat_q[j] <= src_dat[j];
      end
    end
  end

  assign in_rdy  = ~hold[0];
  assign stg_vld = vld_q;
  assign out_vld = vld_q[N_STAGES-1];
  assign out_dat = dat_q[N_STAGES-1];

  pipe_evt_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .evt (|stall),
    .cnt (stall_cnt)
  );

  pipe_evt_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .evt (|flush),
    .cnt (flush_cnt)
  );

endmodule
